// File: rtl/router_pkg.sv
// Shared types, constants and the Hamming(7,4) encoder for the packet router.
package router_pkg;

   localparam int NUM_PORTS = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   // Hamming(7,4): data on bits 2,4,5,6; parity on bits 0,1,3.
   function automatic logic [6:0] hamming_encode(input logic [3:0] d);
      logic [6:0] cw;
      cw[2] = d[0];
      cw[4] = d[1];
      cw[5] = d[2];
      cw[6] = d[3];
      cw[0] = d[0] ^ d[1] ^ d[3];
      cw[1] = d[0] ^ d[2] ^ d[3];
      cw[3] = d[1] ^ d[2] ^ d[3];
      return cw;
   endfunction

endpackage

// File: rtl/router_scheduler_if.sv
// Source/destination bundle of the router.
// Handshake: a source holds req[i]/pkt[i] stable until it sees gnt[i] high for
// one cycle; destination p owns d_out[p] while vld[p] is high and takes it on
// any cycle where rdy[p] is also high.
interface router_scheduler_if;
   import router_pkg::*;

   logic [NUM_PORTS-1:0]      req;
   logic [NUM_PORTS-1:0][5:0] pkt;
   logic [NUM_PORTS-1:0]      gnt;
   logic [NUM_PORTS-1:0][6:0] d_out;
   logic [NUM_PORTS-1:0]      vld;
   logic [NUM_PORTS-1:0]      rdy;

   // Environment side: sources and destinations.
   modport master (
      output req, pkt, rdy,
      input  gnt, d_out, vld
   );

   // Router side.
   modport slave (
      input  req, pkt, rdy,
      output gnt, d_out, vld
   );

endinterface

// File: rtl/rr_arbiter.sv
// 4-way round-robin pick: search starts one past the last winner.
module rr_arbiter
   import router_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [1:0]           ptr_i,
   output logic [NUM_PORTS-1:0] gnt_o
);

   logic [1:0] idx;
   logic       found;

   // First requester at ptr+1, ptr+2, ptr+3, ptr (wrapping) wins.
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         idx = 2'(int'(ptr_i) + i);
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/router_scheduler.sv
// Packet router: grants one source at a time, Hamming-encodes its nibble onto
// the destination port and holds it until rdy or a MAX_WAIT-cycle timeout.
module router_scheduler
   import router_pkg::*;
#(
   parameter int MAX_WAIT = 8
) (
   input  logic                clk,
   input  logic                rst,
   router_scheduler_if.slave   bus,
   output logic                busy,
   output logic [7:0]          drop_cnt,
   output state_e              dbg_state_o
);

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_e                    state_q;
   logic [NUM_PORTS-1:0]      gnt_q;
   logic [NUM_PORTS-1:0]      vld_q;
   logic [NUM_PORTS-1:0][6:0] d_out_q;
   logic [7:0]                wait_q;
   logic [1:0]                ptr_q;
   logic [1:0]                dest_q;
   logic [7:0]                drop_q;

   logic [NUM_PORTS-1:0]      win_onehot;
   logic [1:0]                win_idx;
   logic [5:0]                win_pkt;

   rr_arbiter u_arb (
      .req_i (bus.req),
      .ptr_i (ptr_q),
      .gnt_o (win_onehot)
   );

   // Encode the one-hot winner into an index to select its packet.
   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (win_onehot[i]) win_idx = 2'(i);
      end
   end

   assign win_pkt = bus.pkt[win_idx];

   // Scheduler FSM; every output is a register written here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         vld_q   <= '0;
         d_out_q <= '0;
         wait_q  <= '0;
         ptr_q   <= 2'd3;
         dest_q  <= '0;
         drop_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               gnt_q <= '0;
               if (|bus.req) begin
                  gnt_q                  <= win_onehot;
                  ptr_q                  <= win_idx;
                  dest_q                 <= win_pkt[5:4];
                  d_out_q                <= '0;
                  d_out_q[win_pkt[5:4]]  <= hamming_encode(win_pkt[3:0]);
                  vld_q                  <= 4'b0001 << win_pkt[5:4];
                  wait_q                 <= '0;
                  state_q                <= ST_SEND;
               end
            end
            ST_SEND: begin
               gnt_q <= '0;
               if (bus.rdy[dest_q]) begin
                  vld_q   <= '0;
                  d_out_q <= '0;
                  state_q <= ST_IDLE;
               end else if (wait_q == WAIT_LAST) begin
                  vld_q   <= '0;
                  d_out_q <= '0;
                  if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
                  state_q <= ST_IDLE;
               end else begin
                  wait_q <= wait_q + 8'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.vld     = vld_q;
   assign bus.d_out   = d_out_q;
   assign busy        = (state_q != ST_IDLE);
   assign drop_cnt    = drop_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_router_scheduler.sv
// Bench for router_scheduler: directed vectors, multi-cycle corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_router_scheduler;
   import router_pkg::*;

   localparam int MW_A = 8;
   localparam int MW_B = 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   router_scheduler_if a_if ();
   router_scheduler_if b_if ();

   logic       busy_a, busy_b;
   logic [7:0] drop_a, drop_b;
   state_e     st_a, st_b;

   router_scheduler #(.MAX_WAIT(MW_A)) dut_a (
      .clk(clk), .rst(rst), .bus(a_if.slave),
      .busy(busy_a), .drop_cnt(drop_a), .dbg_state_o(st_a)
   );

   router_scheduler #(.MAX_WAIT(MW_B)) dut_b (
      .clk(clk), .rst(rst), .bus(b_if.slave),
      .busy(busy_b), .drop_cnt(drop_b), .dbg_state_o(st_b)
   );

   // ---------------- scoreboard ----------------
   int errors = 0;
   int checks = 0;
   logic [8:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference Hamming(7,4) built from positional rules: positions 1..7,
   // data in non-power-of-two positions, parity p covers positions with bit p set.
   function automatic logic [6:0] ref_cw(input logic [3:0] d);
      logic [6:0] cw;
      logic       par;
      int         k;
      cw = '0;
      k  = 0;
      for (int pos = 1; pos <= 7; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            cw[pos-1] = d[k];
            k++;
         end
      end
      for (int p = 1; p <= 4; p = p * 2) begin
         par = 1'b0;
         for (int pos = 1; pos <= 7; pos++)
            if (((pos & p) != 0) && (pos != p)) par = par ^ cw[pos-1];
         cw[p-1] = par;
      end
      return cw;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      a_if.req = '0; a_if.rdy = '0; a_if.pkt = '0;
      b_if.req = '0; b_if.rdy = '0; b_if.pkt = '0;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic sample();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [1:0] src;
      logic [5:0] pkt;
      logic [3:0] gnt;
      logic [3:0] vld;
      logic [6:0] cw;
   } vec_t;

   vec_t vecs[6];

   // ---------------- reference model state ----------------
   bit         m_busy;
   int         m_last, m_dest, m_age, m_drops;
   logic [3:0] m_gnt;
   logic [6:0] m_cw;

   task automatic model_reset();
      m_busy = 0; m_last = 3; m_dest = 0; m_age = 0; m_drops = 0;
      m_gnt = '0; m_cw = '0;
      exp_q.delete();
   endtask

   // One clock edge of the router at transaction level.
   task automatic model_step(input logic r, input logic [3:0] req,
                             input logic [3:0][5:0] pkt, input logic [3:0] rdy);
      int  w;
      bit  found;
      if (r) begin
         model_reset();
      end else if (!m_busy) begin
         m_gnt = '0;
         if (req != 0) begin
            found = 0;
            w = 0;
            for (int k = 1; k <= 4; k++) begin
               if (!found && req[(m_last + k) % 4]) begin
                  w = (m_last + k) % 4;
                  found = 1;
               end
            end
            m_last = w;
            m_gnt  = 4'(1 << w);
            m_dest = int'(pkt[w][5:4]);
            m_cw   = ref_cw(pkt[w][3:0]);
            m_age  = 1;
            m_busy = 1;
            exp_q.push_back({2'(m_dest), m_cw});
         end
      end else begin
         m_gnt = '0;
         if (rdy[m_dest]) begin
            m_busy = 0;
         end else if (m_age == MW_A) begin
            m_busy = 0;
            if (m_drops < 255) m_drops++;
         end else begin
            m_age++;
         end
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [3:0][6:0] ed;
      logic [1:0]      dest;
      logic [3:0]      pend;
      logic [8:0]      got, want;
      int              vcount;
      logic            r_now;

      clear_inputs();
      vecs[0] = '{2'd0, 6'b10_1011, 4'b0001, 4'b0100, 7'b1010101};
      vecs[1] = '{2'd3, 6'b00_0000, 4'b1000, 4'b0001, 7'b0000000};
      vecs[2] = '{2'd1, 6'b01_1111, 4'b0010, 4'b0010, 7'b1111111};
      vecs[3] = '{2'd2, 6'b11_0001, 4'b0100, 4'b1000, 7'b0000111};
      vecs[4] = '{2'd0, 6'b00_1000, 4'b0001, 4'b0001, 7'b1001011};
      vecs[5] = '{2'd1, 6'b10_0110, 4'b0010, 4'b0100, 7'b0110011};

      // Reset state.
      sample();
      check("rst_gnt", 32'(a_if.gnt), 0);
      check("rst_vld", 32'(a_if.vld), 0);
      check("rst_dout", 32'(a_if.d_out), 0);
      check("rst_busy", 32'(busy_a), 0);
      check("rst_drop", 32'(drop_a), 0);
      @(negedge clk);
      rst = 1'b0;

      // Directed single-packet vectors, including a zero codeword.
      for (int v = 0; v < 6; v++) begin
         dest = vecs[v].pkt[5:4];
         ed = '0;
         ed[dest] = vecs[v].cw;
         @(negedge clk);
         a_if.req = 4'(1 << vecs[v].src);
         a_if.pkt[vecs[v].src] = vecs[v].pkt;
         a_if.rdy = '0;
         sample();
         check("vec_gnt", 32'(a_if.gnt), 32'(vecs[v].gnt));
         check("vec_vld", 32'(a_if.vld), 32'(vecs[v].vld));
         check("vec_dout", 32'(a_if.d_out), 32'(ed));
         check("vec_busy", 32'(busy_a), 1);
         @(negedge clk);
         a_if.req = '0;
         a_if.rdy = ~(4'(1 << dest));
         sample();
         check("vec_hold_vld", 32'(a_if.vld), 32'(vecs[v].vld));
         check("vec_hold_gnt", 32'(a_if.gnt), 0);
         @(negedge clk);
         a_if.rdy = 4'(1 << dest);
         sample();
         check("vec_done_vld", 32'(a_if.vld), 0);
         check("vec_done_dout", 32'(a_if.d_out), 0);
         check("vec_done_busy", 32'(busy_a), 0);
         @(negedge clk);
         a_if.rdy = '0;
      end

      // Fairness: all sources requesting, all destinations ready.
      reset_dut();
      for (int i = 0; i < 4; i++) a_if.pkt[i] = {2'(i), 4'(i + 5)};
      a_if.req = 4'hF;
      a_if.rdy = 4'hF;
      for (int k = 0; k < 10; k++) begin
         sample();
         check("fair_gnt", 32'(a_if.gnt), (k % 2 == 0) ? 32'(1 << ((k / 2) % 4)) : 0);
      end
      @(negedge clk);
      a_if.req = '0;

      // Timeout on port 1 with rdy asserted only on the other ports.
      reset_dut();
      a_if.req = 4'b0001;
      a_if.pkt[0] = 6'b01_0110;
      a_if.rdy = 4'b1101;
      vcount = 0;
      for (int k = 0; k < 12; k++) begin
         sample();
         if (a_if.vld[1]) vcount++;
         if (k == 0) begin
            @(negedge clk);
            a_if.req = '0;
         end
      end
      check("tmo_vld_cycles", 32'(vcount), 8);
      check("tmo_drop", 32'(drop_a), 1);
      check("tmo_busy", 32'(busy_a), 0);
      check("tmo_vld_low", 32'(a_if.vld), 0);

      // Reset in the third SEND cycle.
      reset_dut();
      a_if.req = 4'b0001;
      a_if.pkt[0] = 6'b10_0011;
      a_if.rdy = '0;
      sample();
      @(negedge clk);
      a_if.req = '0;
      sample();
      sample();
      check("mid_busy_before", 32'(busy_a), 1);
      @(negedge clk);
      rst = 1'b1;
      sample();
      check("mid_vld", 32'(a_if.vld), 0);
      check("mid_dout", 32'(a_if.d_out), 0);
      check("mid_drop", 32'(drop_a), 0);
      check("mid_gnt", 32'(a_if.gnt), 0);
      @(negedge clk);
      rst = 1'b0;
      a_if.req = 4'b0011;
      a_if.pkt[1] = 6'b00_0001;
      sample();
      check("mid_next_gnt", 32'(a_if.gnt), 32'b0001);
      @(negedge clk);
      a_if.req = '0;
      a_if.rdy = 4'hF;
      sample();
      @(negedge clk);
      a_if.rdy = '0;

      // Randomized run against the reference model.
      reset_dut();
      model_reset();
      pend = '0;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               a_if.pkt[i] = 6'($urandom_range(0, 63));
            end
         end
         a_if.req = pend;
         for (int i = 0; i < 4; i++) a_if.rdy[i] = ($urandom_range(0, 3) == 0);
         rst = ($urandom_range(0, 99) == 0);
         r_now = rst;
         @(posedge clk);
         model_step(r_now, a_if.req, a_if.pkt, a_if.rdy);
         #1;
         ed = '0;
         if (m_busy) ed[m_dest] = m_cw;
         check("rnd_gnt", 32'(a_if.gnt), 32'(m_gnt));
         check("rnd_vld", 32'(a_if.vld), m_busy ? 32'(1 << m_dest) : 0);
         check("rnd_dout", 32'(a_if.d_out), 32'(ed));
         check("rnd_busy", 32'(busy_a), 32'(m_busy));
         check("rnd_drop", 32'(drop_a), 32'(m_drops));
         if (a_if.gnt != 0) begin
            got = '0;
            for (int i = 0; i < 4; i++)
               if (a_if.vld[i]) got = {2'(i), a_if.d_out[i]};
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rnd_sb: got %0h expected none", got);
            end else begin
               want = exp_q.pop_front();
               check("rnd_sb", 32'(got), 32'(want));
            end
         end
         pend = pend & ~a_if.gnt;
      end
      check("rnd_sb_empty", 32'(exp_q.size()), 0);

      // Saturation of drop_cnt with MAX_WAIT=1: one drop every two edges.
      reset_dut();
      b_if.req = 4'b0001;
      b_if.pkt[0] = 6'b11_0101;
      b_if.rdy = '0;
      for (int n = 1; n <= 540; n++) begin
         sample();
         if (n == 200 || n == 509 || n == 510 || n == 540)
            check("sat_drop", 32'(drop_b), 32'(((n / 2) > 255) ? 255 : (n / 2)));
      end
      @(negedge clk);
      b_if.req = '0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
